// File: rtl/clock_setter_if.sv
// Front-panel / clock-core connection bundle for the time-entry controller.
// The master side drives buttons and the clock's running time. The slave side
// (clock_setter) returns the edited value, the load strobes and the edit flags.
interface clock_setter_if;
    logic       btn_set;
    logic       btn_inc;
    logic       btn_cancel;
    logic       sel_alarm;
    logic [1:0] H_cur1;
    logic [3:0] H_cur0;
    logic [2:0] M_cur1;
    logic [3:0] M_cur0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       edit_hour;
    logic       edit_min;

    modport master (
        output btn_set, btn_inc, btn_cancel, sel_alarm,
        output H_cur1, H_cur0, M_cur1, M_cur0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, edit_hour, edit_min
    );

    modport slave (
        input  btn_set, btn_inc, btn_cancel, sel_alarm,
        input  H_cur1, H_cur0, M_cur1, M_cur0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, edit_hour, edit_min
    );
endinterface

// File: rtl/clock_setter.sv
// Button-driven time-entry controller. Preloads BCD hour/minute from the
// running clock (or the alarm shadow), lets the user step hour then minute,
// and commits with an LD_CYCLES-wide LD_time or LD_alarm pulse.
module clock_setter #(
    parameter int LD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    clock_setter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

    state_t     state_reg, state_next;
    logic       target_reg, target_next;      // 1 = editing alarm time
    logic [1:0] h1_reg, h1_next;
    logic [3:0] h0_reg, h0_next;
    logic [2:0] m1_reg, m1_next;
    logic [3:0] m0_reg, m0_next;
    logic [1:0] sh_h1_reg, sh_h1_next;        // alarm shadow
    logic [3:0] sh_h0_reg, sh_h0_next;
    logic [2:0] sh_m1_reg, sh_m1_next;
    logic [3:0] sh_m0_reg, sh_m0_next;
    logic [2:0] cnt_reg, cnt_next;            // commit pulse cycle counter
    logic       set_q_reg, inc_q_reg, cancel_q_reg;
    logic       ld_time_reg, ld_alarm_reg, edit_hour_reg, edit_min_reg;

    logic set_rise, inc_rise, cancel_rise;
    assign set_rise    = bus.btn_set    & ~set_q_reg;
    assign inc_rise    = bus.btn_inc    & ~inc_q_reg;
    assign cancel_rise = bus.btn_cancel & ~cancel_q_reg;

    // BCD hour step 00..23; any out-of-range value snaps to 00
    function automatic logic [5:0] hour_step(input logic [1:0] t, input logic [3:0] o);
        if (t > 2'd2 || o > 4'd9 || (t == 2'd2 && o >= 4'd3))
            hour_step = 6'd0;
        else if (o == 4'd9)
            hour_step = {t + 2'd1, 4'd0};
        else
            hour_step = {t, o + 4'd1};
    endfunction

    // BCD minute step 00..59; wraps without carry, out-of-range snaps to 00
    function automatic logic [6:0] min_step(input logic [2:0] t, input logic [3:0] o);
        if (t > 3'd5 || o > 4'd9 || (t == 3'd5 && o == 4'd9))
            min_step = 7'd0;
        else if (o == 4'd9)
            min_step = {t + 3'd1, 4'd0};
        else
            min_step = {t, o + 4'd1};
    endfunction

    // Next-state, edit-field and shadow logic; cancel > set > inc
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        h1_next     = h1_reg;
        h0_next     = h0_reg;
        m1_next     = m1_reg;
        m0_next     = m0_reg;
        sh_h1_next  = sh_h1_reg;
        sh_h0_next  = sh_h0_reg;
        sh_m1_next  = sh_m1_reg;
        sh_m0_next  = sh_m0_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (set_rise) begin
                    target_next = bus.sel_alarm;
                    if (bus.sel_alarm) begin
                        h1_next = sh_h1_reg;
                        h0_next = sh_h0_reg;
                        m1_next = sh_m1_reg;
                        m0_next = sh_m0_reg;
                    end else begin
                        h1_next = bus.H_cur1;
                        h0_next = bus.H_cur0;
                        m1_next = bus.M_cur1;
                        m0_next = bus.M_cur0;
                    end
                    state_next = EDIT_H;
                end
            end
            EDIT_H: begin
                if (cancel_rise)
                    state_next = IDLE;
                else if (set_rise)
                    state_next = EDIT_M;
                else if (inc_rise)
                    {h1_next, h0_next} = hour_step(h1_reg, h0_reg);
            end
            EDIT_M: begin
                if (cancel_rise) begin
                    state_next = IDLE;
                end else if (set_rise) begin
                    state_next = COMMIT;
                    cnt_next   = 3'd0;
                    if (target_reg) begin
                        sh_h1_next = h1_reg;
                        sh_h0_next = h0_reg;
                        sh_m1_next = m1_reg;
                        sh_m0_next = m0_reg;
                    end
                end else if (inc_rise) begin
                    {m1_next, m0_next} = min_step(m1_reg, m0_reg);
                end
            end
            COMMIT: begin
                if (cnt_reg == 3'(LD_CYCLES - 1))
                    state_next = IDLE;
                else
                    cnt_next = cnt_reg + 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Datapath, edge-detect flops and registered outputs decoded from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_reg    <= 1'b0;
            h1_reg        <= '0;
            h0_reg        <= '0;
            m1_reg        <= '0;
            m0_reg        <= '0;
            sh_h1_reg     <= '0;
            sh_h0_reg     <= '0;
            sh_m1_reg     <= '0;
            sh_m0_reg     <= '0;
            cnt_reg       <= '0;
            set_q_reg     <= 1'b1;
            inc_q_reg     <= 1'b1;
            cancel_q_reg  <= 1'b1;
            ld_time_reg   <= 1'b0;
            ld_alarm_reg  <= 1'b0;
            edit_hour_reg <= 1'b0;
            edit_min_reg  <= 1'b0;
        end else begin
            target_reg    <= target_next;
            h1_reg        <= h1_next;
            h0_reg        <= h0_next;
            m1_reg        <= m1_next;
            m0_reg        <= m0_next;
            sh_h1_reg     <= sh_h1_next;
            sh_h0_reg     <= sh_h0_next;
            sh_m1_reg     <= sh_m1_next;
            sh_m0_reg     <= sh_m0_next;
            cnt_reg       <= cnt_next;
            set_q_reg     <= bus.btn_set;
            inc_q_reg     <= bus.btn_inc;
            cancel_q_reg  <= bus.btn_cancel;
            ld_time_reg   <= (state_next == COMMIT) && !target_next;
            ld_alarm_reg  <= (state_next == COMMIT) &&  target_next;
            edit_hour_reg <= (state_next == EDIT_H);
            edit_min_reg  <= (state_next == EDIT_M);
        end
    end

    assign bus.H_in1     = h1_reg;
    assign bus.H_in0     = h0_reg;
    assign bus.M_in1     = m1_reg;
    assign bus.M_in0     = m0_reg;
    assign bus.LD_time   = ld_time_reg;
    assign bus.LD_alarm  = ld_alarm_reg;
    assign bus.edit_hour = edit_hour_reg;
    assign bus.edit_min  = edit_min_reg;
endmodule

// File: tb/tb_clock_setter.sv
// Directed bench for clock_setter: time edit, wraps, alarm shadow,
// coincident edges, cancel, out-of-range preload and reset mid-commit.
module tb_clock_setter;
    localparam int LDC = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    clock_setter_if bus ();
    clock_setter #(.LD_CYCLES(LDC)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [12:0] bcd(input int h, input int m);
        bcd = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [12:0] shown();
        shown = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pulse any combination of buttons for one cycle; returns at the
    // falling edge right after the detecting rising edge.
    task automatic press(input logic s, input logic i, input logic c);
        @(negedge clk);
        bus.btn_set = s; bus.btn_inc = i; bus.btn_cancel = c;
        @(negedge clk);
        bus.btn_set = 1'b0; bus.btn_inc = 1'b0; bus.btn_cancel = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_cur(input int h, input int m);
        {bus.H_cur1, bus.H_cur0, bus.M_cur1, bus.M_cur0} = bcd(h, m);
    endtask

    // Called right after the final set; counts strobe-high cycles over a window
    task automatic strobe_window(input string tag, output int nt, output int na, output int bad);
        nt = 0; na = 0; bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.LD_time) nt++;
            if (bus.LD_alarm) na++;
            if ((bus.LD_time || bus.LD_alarm) && shown() !== bcd(13, 30) && tag == "time") bad++;
            if (k < 5) @(negedge clk);
        end
    endtask

    int nt, na, bad;

    initial begin
        reset = 1'b1;
        bus.btn_set = 1'b1; bus.btn_inc = 1'b0; bus.btn_cancel = 1'b0;
        bus.sel_alarm = 1'b0;
        set_cur(0, 0);
        repeat (3) @(negedge clk);
        check("reset_val", 16'(shown()), 16'(bcd(0, 0)));
        check("reset_flags", 16'({bus.LD_time, bus.LD_alarm, bus.edit_hour, bus.edit_min}), 16'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("held_set_no_edge", 16'({bus.edit_hour, bus.edit_min}), 16'h0);
        bus.btn_set = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_val", 16'(shown()), 16'(bcd(0, 0)));

        // Inc and cancel in IDLE are ignored
        press(1'b0, 1'b1, 1'b1);
        check("idle_inc_ignored", 16'({shown(), bus.edit_hour}), 16'({bcd(0, 0), 1'b0}));

        // Time edit 11:26 -> 13:30
        set_cur(11, 26);
        press(1'b1, 1'b0, 1'b0);
        check("time_preload", 16'(shown()), 16'(bcd(11, 26)));
        check("edit_hour_flag", 16'({bus.edit_hour, bus.edit_min}), 16'b10);
        incs(2);
        check("time_hour13", 16'(shown()), 16'(bcd(13, 26)));
        press(1'b1, 1'b0, 1'b0);
        check("edit_min_flag", 16'({bus.edit_hour, bus.edit_min}), 16'b01);
        incs(4);
        check("time_min30", 16'(shown()), 16'(bcd(13, 30)));
        press(1'b1, 1'b0, 1'b0);
        strobe_window("time", nt, na, bad);
        check("ld_time_width", 16'(nt), 16'(LDC));
        check("ld_alarm_quiet", 16'(na), 16'h0);
        check("commit_val_stable", 16'(bad), 16'h0);
        check("after_commit_idle", 16'({bus.edit_hour, bus.edit_min, bus.LD_time}), 16'h0);

        // Alarm edit: hour and minute wraps
        bus.sel_alarm = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        check("alarm_preload0", 16'(shown()), 16'(bcd(0, 0)));
        incs(23);
        check("hour_23", 16'(shown()), 16'(bcd(23, 0)));
        incs(1);
        check("hour_wrap_00", 16'(shown()), 16'(bcd(0, 0)));
        incs(1);
        press(1'b1, 1'b0, 1'b0);
        incs(59);
        check("min_59", 16'(shown()), 16'(bcd(1, 59)));
        incs(1);
        check("min_wrap_no_carry", 16'(shown()), 16'(bcd(1, 0)));
        press(1'b1, 1'b0, 1'b0);
        strobe_window("alarm", nt, na, bad);
        check("ld_alarm_width", 16'(nt * 16 + na), 16'(LDC));
        press(1'b1, 1'b0, 1'b0);
        check("alarm_reload", 16'(shown()), 16'(bcd(1, 0)));

        // Alarm shadow: set 11:30, re-entry ignores H_cur
        incs(10);
        press(1'b1, 1'b0, 1'b0);
        incs(30);
        check("alarm_1130", 16'(shown()), 16'(bcd(11, 30)));
        press(1'b1, 1'b0, 1'b0);
        repeat (LDC + 2) @(negedge clk);
        set_cur(4, 45);
        press(1'b1, 1'b0, 1'b0);
        check("shadow_preload", 16'(shown()), 16'(bcd(11, 30)));

        // Set+inc in EDIT_H: advance, hour unchanged
        press(1'b1, 1'b1, 1'b0);
        check("set_inc_state", 16'({bus.edit_hour, bus.edit_min}), 16'b01);
        check("set_inc_hour", 16'(shown()), 16'(bcd(11, 30)));
        incs(1);
        // Cancel+set in EDIT_M: abort, no strobe
        press(1'b1, 1'b0, 1'b1);
        strobe_window("cancel", nt, na, bad);
        check("cancel_set_nostrobe", 16'({8'(nt), 8'(na)}), 16'h0);
        check("cancel_keeps_val", 16'(shown()), 16'(bcd(11, 31)));
        check("cancel_idle", 16'({bus.edit_hour, bus.edit_min}), 16'h0);

        // Cancel after edits: shadow unchanged
        press(1'b1, 1'b0, 1'b0);
        check("shadow_kept1", 16'(shown()), 16'(bcd(11, 30)));
        incs(2);
        press(1'b1, 1'b0, 1'b0);
        incs(3);
        press(1'b0, 1'b0, 1'b1);
        strobe_window("cancel2", nt, na, bad);
        check("cancel2_nostrobe", 16'({8'(nt), 8'(na)}), 16'h0);
        press(1'b1, 1'b0, 1'b0);
        check("shadow_kept2", 16'(shown()), 16'(bcd(11, 30)));
        press(1'b0, 1'b0, 1'b1);

        // Out-of-range preload: first inc forces 00
        bus.sel_alarm = 1'b0;
        {bus.H_cur1, bus.H_cur0, bus.M_cur1, bus.M_cur0} = {2'd2, 4'd9, 3'd7, 4'd12};
        press(1'b1, 1'b0, 1'b0);
        incs(1);
        check("bad_hour_to_00", 16'({bus.H_in1, bus.H_in0}), 16'h0);
        press(1'b1, 1'b0, 1'b0);
        incs(1);
        check("bad_min_to_00", 16'(shown()), 16'(bcd(0, 0)));
        press(1'b0, 1'b0, 1'b1);

        // Reset during a strobe drops it asynchronously
        set_cur(5, 7);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("strobe_before_reset", 16'(bus.LD_time), 16'h1);
        #1 reset = 1'b1;
        #1;
        check("reset_drops_strobe", 16'({bus.LD_time, bus.LD_alarm}), 16'h0);
        check("reset_clears_val", 16'(shown()), 16'(bcd(0, 0)));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 16'({bus.edit_hour, bus.edit_min, bus.LD_time}), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
